// File: rtl/imem_responder.sv
// Instruction memory responder: fixed-latency fetch FSM over a loadable word RAM.
// Optional next-line prefetch buffer compiled in with IMEM_PREFETCH_EN.
module imem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req,
    input  logic [31:0]              i_pc,
    output logic                     o_ready,
    output logic [31:0]              o_instr,
    output logic                     o_valid,
    output logic                     o_addr_err,
    input  logic                     i_prog_we,
    input  logic [$clog2(DEPTH)-1:0] i_prog_addr,
    input  logic [31:0]              i_prog_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_instr;
    logic          r_valid;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic          w_err;
    logic          w_accept;
    logic          w_hit;
    logic [31:0]   w_hit_data;

    assign w_idx    = i_pc[AW+1:2];
    assign w_err    = (i_pc[1:0] != 2'b00) | (|i_pc[31:AW+2]);
    assign o_ready  = (r_state == S_IDLE) & ~i_rst;
    assign w_accept = i_req & o_ready;

    assign o_instr    = r_instr;
    assign o_valid    = r_valid;
    assign o_addr_err = r_err;

    // Program port has no reset so contents survive Rst.
    always_ff @(posedge i_clk) begin
        if (i_prog_we) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx <= w_idx;
                        if (w_err) begin
                            r_state <= S_RESP;
                            r_instr <= 32'd0;
                            r_err   <= 1'b1;
                            r_valid <= 1'b1;
                        end else if (w_hit) begin
                            r_state <= S_RESP;
                            r_instr <= w_hit_data;
                            r_err   <= 1'b0;
                            r_valid <= 1'b1;
                        end else if (LATENCY == 1) begin
                            r_state <= S_RESP;
                            r_instr <= r_mem[w_idx];
                            r_err   <= 1'b0;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        r_instr <= r_mem[r_idx];
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_PREFETCH_EN
    logic          r_pf_valid;
    logic          r_pf_fill;
    logic [AW-1:0] r_pf_tag;
    logic [31:0]   r_pf_data;

    logic [AW-1:0] w_next_idx;
    logic          w_last;
    logic          w_fill_now;
    logic [AW-1:0] w_guard_tag;

    assign w_next_idx  = r_idx + 1'b1;
    assign w_last      = (r_idx == AW'(DEPTH - 1));
    // A fill pending on this edge makes any same-edge request a miss.
    assign w_hit       = r_pf_valid & ~r_pf_fill & (r_pf_tag == w_idx);
    assign w_hit_data  = r_pf_data;
    assign w_fill_now  = r_pf_fill & (r_state == S_IDLE) & ~w_accept;
    assign w_guard_tag = w_fill_now ? w_next_idx : r_pf_tag;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pf_valid <= 1'b0;
            r_pf_fill  <= 1'b0;
            r_pf_tag   <= '0;
            r_pf_data  <= 32'd0;
        end else begin
            r_pf_fill <= (r_state == S_RESP) & ~r_err & ~w_last;
            if (w_fill_now) begin
                r_pf_valid <= 1'b1;
                r_pf_tag   <= w_next_idx;
                r_pf_data  <= r_mem[w_next_idx];
            end
            if (w_accept & ~w_err & ~w_hit) begin
                r_pf_valid <= 1'b0;
            end
            if (i_prog_we & (i_prog_addr == w_guard_tag)) begin
                r_pf_valid <= 1'b0;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 32'd0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expectations queued at drive time,
// popped and compared whenever the DUT pulses Valid.
module tb_imem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int AW    = 10;
`ifdef IMEM_PREFETCH_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = LAT;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [31:0]   pc;
    logic          ready;
    logic [31:0]   instr;
    logic          valid;
    logic          err;
    logic          we;
    logic [AW-1:0] paddr;
    logic [31:0]   pdata;

    imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_pc        (pc),
        .o_ready     (ready),
        .o_instr     (instr),
        .o_valid     (valid),
        .o_addr_err  (err),
        .i_prog_we   (we),
        .i_prog_addr (paddr),
        .i_prog_data (pdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            exp_t e;
            n_valid++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got Valid instr=%h cyc=%0d, required none",
                         instr, cyc);
            end else begin
                e = sb.pop_front();
                if (instr !== e.instr) begin
                    n_fail++;
                    $display("FAIL sb_instr: got %h, required %h", instr, e.instr);
                end
                n_checks++;
                if (err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_addr_err: got %b, required %b", err, e.err);
                end
                n_checks++;
                if (cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL sb_latency: Valid at cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: got ready=%b, required 1", ready);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] ei,
                         input logic ee, input int lat);
        wait_ready();
        req = 1'b1;
        pc  = a;
        sb.push_back('{ei, ee, cyc + lat});
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic prog_write(input logic [AW-1:0] a, input logic [31:0] d);
        we    = 1'b1;
        paddr = a;
        pdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; pc = 32'd0;
        we = 1'b0; paddr = '0; pdata = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_ready: got %b, required 0", ready);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid: got %b, required 0", valid);
        end
        n_checks++;
        if (instr !== 32'd0) begin
            n_fail++; $display("FAIL rst_instr: got %h, required 0", instr);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL rst_addr_err: got %b, required 0", err);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_release_ready: got %b, required 1", ready);
        end
        @(negedge clk);
        prog_write(10'd0, 32'h11);
        prog_write(10'd1, 32'h22);
        prog_write(10'd2, 32'h33);
        prog_write(10'd3, 32'h44);
        prog_write(10'(DEPTH - 1), 32'hDEAD_BEEF);
    endtask

    task automatic test_normal();
        issue(32'h8,   32'h33, 1'b0, LAT); drain();
        issue(32'h0,   32'h11, 1'b0, LAT); drain();
        issue(32'hC,   32'h44, 1'b0, LAT); drain();
        issue(32'hFFC, 32'hDEAD_BEEF, 1'b0, LAT); drain();
    endtask

    task automatic test_error();
        issue(32'h6,    32'd0, 1'b1, 1); drain();
        issue(32'h1000, 32'd0, 1'b1, 1); drain();
        issue(32'h3,    32'd0, 1'b1, 1); drain();
    endtask

    task automatic test_hold_req();
        int v0;
        wait_ready();
        v0  = n_valid;
        req = 1'b1;
        pc  = 32'h4;
        for (int i = 0; i < 3 * (LAT + 1); i++) begin
            n_checks++;
            if (ready !== ((i % (LAT + 1)) == 0)) begin
                n_fail++;
                $display("FAIL hold_ready: step %0d got %b, required %b",
                         i, ready, (i % (LAT + 1)) == 0);
            end
            if ((i % (LAT + 1)) == 0) sb.push_back('{32'h22, 1'b0, cyc + LAT});
            @(negedge clk);
        end
        req = 1'b0;
        drain();
        n_checks++;
        if ((n_valid - v0) !== 3) begin
            n_fail++;
            $display("FAIL hold_valid_count: got %0d, required 3", n_valid - v0);
        end
    endtask

    task automatic test_reset_mid();
        wait_ready();
        req = 1'b1;
        pc  = 32'h4;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_valid: got %b, required 0", valid);
        end
        n_checks++;
        if (instr !== 32'd0) begin
            n_fail++; $display("FAIL abort_instr: got %h, required 0", instr);
        end
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_ready: got %b, required 0", ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_release_ready: got %b, required 1", ready);
        end
        repeat (4) @(negedge clk);
        issue(32'h4, 32'h22, 1'b0, LAT);
        drain();
    endtask

    task automatic test_rw_collision();
        wait_ready();
        req = 1'b1;
        pc  = 32'h8;
        sb.push_back('{32'h33, 1'b0, cyc + LAT});
        @(negedge clk);
        req = 1'b0;
        repeat (LAT - 2) @(negedge clk);
        prog_write(10'd2, 32'h77);
        drain();
        issue(32'h8, 32'h77, 1'b0, LAT);
        drain();
    endtask

    task automatic test_prefetch();
        issue(32'h0, 32'h11, 1'b0, LAT);
        drain();
        repeat (3) @(negedge clk);
        issue(32'h4, 32'h22, 1'b0, HIT_LAT);
        drain();
        issue(32'h0, 32'h11, 1'b0, LAT);
        drain();
        repeat (3) @(negedge clk);
        prog_write(10'd1, 32'h99);
        repeat (2) @(negedge clk);
        issue(32'h4, 32'h99, 1'b0, LAT);
        drain();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_error();
        test_hold_req();
        test_reset_mid();
        test_rw_collision();
        test_prefetch();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
